// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory image loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_DRAIN,
        S_DONE,
        S_ERR
    } state_t;

    localparam int unsigned LEN_BYTES      = 2;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned WCOUNT_W       = 8 * LEN_BYTES;
    localparam int unsigned CNT_W          = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Little-endian byte packer: the first byte of a word ends up in word[7:0].
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clear,
    input  logic                          shift_en,
    input  logic [7:0]                    byte_in,
    output logic [8*BYTES_PER_WORD-1:0]   word,
    output logic                          word_complete
);

    logic [CNT_W-1:0] cnt;

    // High on the shift that brings in the last byte; word holds the result next cycle.
    assign word_complete = shift_en && (cnt == CNT_W'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word <= '0;
            cnt  <= '0;
        end else if (clear) begin
            cnt  <= '0;
        end else if (shift_en) begin
            word <= {byte_in, word[8*BYTES_PER_WORD-1:8]};
            cnt  <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Receives a length-prefixed byte stream and writes it word by word into the
// instruction memory, holding the CPU in reset until the image is committed.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned                ADDRESS_WIDTH = 32,
    parameter int unsigned                DATA_WIDTH    = 32,
    parameter logic [ADDRESS_WIDTH-1:0]   BASE_ADDR     = '0,
    parameter int unsigned                MAX_WORDS     = 1024
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [7:0]               byte_in,
    input  logic                     byte_valid,
    output logic                     byte_ready,
    output logic                     wr_en,
    output logic [ADDRESS_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0]    wr_data,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic                     cpu_hold
);

    state_t              state;
    logic [WCOUNT_W-1:0] len;
    logic [WCOUNT_W-1:0] idx;
    logic [WCOUNT_W-1:0] n_full;
    logic                xfer;
    logic                pk_clear;
    logic                pk_shift;
    logic                word_complete;
    logic [DATA_WIDTH-1:0] pk_word;

    assign xfer     = byte_valid && byte_ready;
    assign n_full   = {byte_in, len[7:0]};
    assign pk_clear = start && (state == S_IDLE || state == S_DONE || state == S_ERR);
    assign pk_shift = xfer && (state == S_DATA);
    assign wr_data  = pk_word;

    byte_packer u_packer (
        .clk           (clk),
        .rst_n         (rst_n),
        .clear         (pk_clear),
        .shift_en      (pk_shift),
        .byte_in       (byte_in),
        .word          (pk_word),
        .word_complete (word_complete)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            len        <= '0;
            idx        <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= BASE_ADDR;
            byte_ready <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            cpu_hold   <= 1'b1;
        end else begin
            wr_en <= 1'b0;
            unique case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state      <= S_LEN_LO;
                        idx        <= '0;
                        byte_ready <= 1'b1;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        err        <= 1'b0;
                        cpu_hold   <= 1'b1;
                    end
                end
                S_LEN_LO: begin
                    if (xfer) begin
                        len[7:0] <= byte_in;
                        state    <= S_LEN_HI;
                    end
                end
                S_LEN_HI: begin
                    if (xfer) begin
                        len[15:8] <= byte_in;
                        if (n_full == '0) begin
                            state      <= S_DONE;
                            byte_ready <= 1'b0;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                            cpu_hold   <= 1'b0;
                        end else if (32'(n_full) > MAX_WORDS) begin
                            state      <= S_ERR;
                            byte_ready <= 1'b0;
                            busy       <= 1'b0;
                            err        <= 1'b1;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    // idx advances with the write; stop accepting once the last word is in.
                    if (word_complete) begin
                        wr_en   <= 1'b1;
                        wr_addr <= BASE_ADDR + ADDRESS_WIDTH'({idx, 2'b00});
                        idx     <= idx + WCOUNT_W'(1);
                        if (idx == len - WCOUNT_W'(1))
                            byte_ready <= 1'b0;
                    end
                    if (wr_en && idx == len)
                        state <= S_DRAIN;
                end
                S_DRAIN: begin
                    state    <= S_DONE;
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    cpu_hold <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Table-driven bench for imem_loader with a write scoreboard.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;
    logic        err;
    logic        cpu_hold;

    imem_loader #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .BASE_ADDR(32'h0), .MAX_WORDS(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .cpu_hold   (cpu_hold)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic [15:0]       n;
        int unsigned       sent;
        logic [3:0][31:0]  w;
        bit                gap;
        bit                exp_done;
        bit                exp_err;
        int unsigned       settle;
    } vec_t;

    localparam int NV = 8;
    vec_t vecs [NV];
    vec_t v;
    wr_t  sb [$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Every write strobe must match the oldest outstanding expected write.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && wr_en === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr %h data %h expected no write", wr_addr, wr_data);
            end else begin
                wr_t e;
                e = sb.pop_front();
                if (wr_addr !== e.addr || wr_data !== e.data) begin
                    errors++;
                    $display("FAIL write: got addr %h data %h expected addr %h data %h",
                             wr_addr, wr_data, e.addr, e.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int t;
        t = 0;
        if (gap) tick();
        byte_in    = b;
        byte_valid = 1'b1;
        while (byte_ready !== 1'b1 && t < 50) begin
            tick();
            t++;
        end
        if (t >= 50) begin
            errors++;
            $display("FAIL byte_ready_timeout: got byte_ready %b expected 1", byte_ready);
        end
        tick();
        byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit gap);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gap);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic set_vec(input int i, input logic [15:0] n, input int unsigned sent,
                           input logic [3:0][31:0] w, input bit gap, input bit d,
                           input bit e, input int unsigned settle);
        vecs[i].n = n; vecs[i].sent = sent; vecs[i].w = w; vecs[i].gap = gap;
        vecs[i].exp_done = d; vecs[i].exp_err = e; vecs[i].settle = settle;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; byte_in = 8'h00; byte_valid = 1'b0;
        set_vec(0, 16'd2,   2, {32'h0, 32'h0, 32'h00500093, 32'h00000013}, 1'b0, 1'b1, 1'b0, 2);
        set_vec(1, 16'd2,   2, {32'h0, 32'h0, 32'h00500093, 32'h00000013}, 1'b1, 1'b1, 1'b0, 2);
        set_vec(2, 16'd0,   0, '0,                                          1'b0, 1'b1, 1'b0, 0);
        set_vec(3, 16'd5,   0, '0,                                          1'b0, 1'b0, 1'b1, 0);
        set_vec(4, 16'd1,   1, {32'h0, 32'h0, 32'h0, 32'hDEADBEEF},         1'b0, 1'b1, 1'b0, 2);
        set_vec(5, 16'd4,   4, {32'h44332211, 32'hA5A55A5A, 32'h0F0F0F0F, 32'h12345678}, 1'b0, 1'b1, 1'b0, 2);
        set_vec(6, 16'h100, 0, '0,                                          1'b0, 1'b0, 1'b1, 0);
        set_vec(7, 16'd3,   3, {32'h0, 32'hCAFEF00D, 32'h80000001, 32'h7FFFFFFE}, 1'b1, 1'b1, 1'b0, 2);

        repeat (3) tick();
        chk("rst_byte_ready", {31'b0, byte_ready}, 0);
        chk("rst_wr_en",      {31'b0, wr_en},      0);
        chk("rst_wr_addr",    wr_addr,             0);
        chk("rst_wr_data",    wr_data,             0);
        chk("rst_busy",       {31'b0, busy},       0);
        chk("rst_done",       {31'b0, done},       0);
        chk("rst_err",        {31'b0, err},        0);
        chk("rst_cpu_hold",   {31'b0, cpu_hold},   1);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < NV; i++) begin
            v = vecs[i];
            pulse_start();
            chk($sformatf("v%0d_busy_after_start", i), {31'b0, busy}, 1);
            send_byte(v.n[7:0], v.gap);
            send_byte(v.n[15:8], v.gap);
            for (int w = 0; w < int'(v.sent); w++) begin
                sb.push_back('{addr: 32'(w * 4), data: v.w[w]});
                send_word(v.w[w], v.gap);
            end
            if (v.settle == 2) begin
                chk($sformatf("v%0d_done_early", i), {31'b0, done}, 0);
                tick();
                chk($sformatf("v%0d_drain_busy", i), {31'b0, busy}, 1);
                chk($sformatf("v%0d_drain_done", i), {31'b0, done}, 0);
                tick();
            end
            chk($sformatf("v%0d_done", i),       {31'b0, done},       {31'b0, v.exp_done});
            chk($sformatf("v%0d_err", i),        {31'b0, err},        {31'b0, v.exp_err});
            chk($sformatf("v%0d_cpu_hold", i),   {31'b0, cpu_hold},   {31'b0, !v.exp_done});
            chk($sformatf("v%0d_byte_ready", i), {31'b0, byte_ready}, 0);
            chk($sformatf("v%0d_busy", i),       {31'b0, busy},       0);
            chk($sformatf("v%0d_sb_empty", i),   sb.size(),           0);
        end

        // start pulsed mid-DATA must be ignored
        pulse_start();
        send_byte(8'h02, 1'b0);
        send_byte(8'h00, 1'b0);
        sb.push_back('{addr: 32'h0, data: 32'h11111111});
        send_word(32'h11111111, 1'b0);
        sb.push_back('{addr: 32'h4, data: 32'h22222222});
        start = 1'b1;
        send_byte(8'h22, 1'b0);
        start = 1'b0;
        for (int k = 1; k < 4; k++) send_byte(8'h22, 1'b0);
        tick(); tick();
        chk("start_in_data_done", {31'b0, done}, 1);
        chk("start_in_data_sb",   sb.size(),     0);

        // stream bytes offered while in ERR are not consumed
        pulse_start();
        send_byte(8'h05, 1'b0);
        send_byte(8'h00, 1'b0);
        byte_in = 8'hFF; byte_valid = 1'b1;
        repeat (6) tick();
        byte_valid = 1'b0;
        chk("err_hold_err",   {31'b0, err},        1);
        chk("err_hold_ready", {31'b0, byte_ready}, 0);
        chk("err_hold_cpu",   {31'b0, cpu_hold},   1);

        // asynchronous reset mid-load discards the partial word
        pulse_start();
        send_byte(8'h02, 1'b0);
        send_byte(8'h00, 1'b0);
        sb.push_back('{addr: 32'h0, data: 32'h0BADF00D});
        send_word(32'h0BADF00D, 1'b0);
        send_byte(8'h77, 1'b0);
        send_byte(8'h66, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_wr_data",  wr_data,             0);
        chk("midrst_wr_addr",  wr_addr,             0);
        chk("midrst_busy",     {31'b0, busy},       0);
        chk("midrst_ready",    {31'b0, byte_ready}, 0);
        chk("midrst_cpu_hold", {31'b0, cpu_hold},   1);
        tick();
        rst_n = 1'b1;
        tick();
        pulse_start();
        send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b0);
        sb.push_back('{addr: 32'h0, data: 32'h55AA00FF});
        send_word(32'h55AA00FF, 1'b0);
        tick(); tick();
        chk("restart_done",     {31'b0, done},     1);
        chk("restart_cpu_hold", {31'b0, cpu_hold}, 0);
        chk("restart_sb",       sb.size(),         0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Writer-side companion to the instruction memory. It receives a program image as a byte stream, packs little-endian bytes into 32-bit words and emits one word-aligned write per word into the instruction memory's write port. It holds the CPU in reset until the image is fully committed. It sits between the boot byte source (UART/testbench) and the instruction memory.

## Interface
Parameters:
- ADDRESS_WIDTH, 32, width of the byte address driven to the memory
- DATA_WIDTH, 32, word width; fixed at 32 (4 bytes per word)
- BASE_ADDR, 0, byte address of the first word written
- MAX_WORDS, 1024, largest accepted image length in words

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  pulse; begins a load from IDLE, DONE or ERR
- byte_in  in  8  stream data byte
- byte_valid  in  1  byte_in is valid
- byte_ready  out  1  loader accepts a byte this cycle
- wr_en  out  1  one-cycle word write strobe
- wr_addr  out  ADDRESS_WIDTH  byte address of the write, always a multiple of 4
- wr_data  out  DATA_WIDTH  packed word
- busy  out  1  load in progress
- done  out  1  image fully written
- err  out  1  length rejected
- cpu_hold  out  1  keep CPU in reset

## Operation
- Stream format: 2-byte word count N (low byte first), then 4·N payload bytes. Each word is little-endian: the first byte goes to wr_data[7:0].
- A byte transfers on a rising edge where byte_valid && byte_ready.
- States: IDLE, LEN_LO, LEN_HI, DATA, DRAIN, DONE, ERR.
- IDLE, DONE or ERR with start=1 → LEN_LO. This clears the word index, byte count, done and err. start in any other state is ignored.
- LEN_LO, on transfer: latch N[7:0] → LEN_HI.
- LEN_HI, on transfer: latch N[15:8].
  - N==0 → DONE.
  - N>MAX_WORDS → ERR.
  - Otherwise → DATA.
- DATA, on transfer: shift the byte into the packer and increment the 2-bit byte count.
  - On the 4th byte, the next cycle has wr_en=1, wr_data=the packed word, wr_addr=BASE_ADDR + 4·idx (modulo 2^ADDRESS_WIDTH). idx then increments.
  - If that word was word N-1 → DRAIN. Otherwise stay in DATA.
- DRAIN: exactly one cycle, so the final write commits → DONE.
- DONE: done=1 and cpu_hold=0, held until start or reset.
- ERR: err=1 and cpu_hold=1, held until start or reset. No write ever issues for a rejected length.
- byte_ready = 1 in LEN_LO, LEN_HI and DATA, else 0. The memory has no backpressure.
- busy = 1 in LEN_LO, LEN_HI, DATA and DRAIN.
- cpu_hold = 1 in every state except DONE.
- byte_valid in IDLE, DONE or ERR is ignored; nothing is consumed.

## Timing
- Reset values: byte_ready=0, wr_en=0, wr_addr=BASE_ADDR, wr_data=0, busy=0, done=0, err=0, cpu_hold=1. State = IDLE.
- Reset mid-load: everything returns to reset values immediately (asynchronous). A partial word is discarded and no wr_en is issued.
- Write latency: wr_en is high in the cycle after the edge that accepts the 4th byte of a word. It is high for one cycle only.
- Back-to-back bytes with byte_valid held high give one write every 4 cycles. wr_en never exceeds one per 4 accepted bytes.
- done rises 2 cycles after the edge accepting the last byte: one cycle of wr_en, then DRAIN.
- Gaps in byte_valid stall the packer without losing state.
- N==MAX_WORDS is accepted. The last address is BASE_ADDR + 4·(MAX_WORDS-1).

## Structure
- Package imem_loader_pkg:
  - state_t enum (7 states)
  - LEN_BYTES=2
  - BYTES_PER_WORD=4
  - word-count width constant = 16
- Sub-module byte_packer:
  - 32-bit shift register plus 2-bit count
  - inputs: byte, shift enable and clear
  - outputs: word and word_complete
- The FSM, word index and write-port registers live in imem_loader.

## Test plan
- Reset, then start; stream 02 00, 13 00 00 00, 93 00 50 00 → writes (addr 0, 0x00000013) and (addr 4, 0x00500093). done high 2 cycles after the last byte, then cpu_hold=0.
- Same image with byte_valid toggling every other cycle → identical writes and data, no extra wr_en.
- Length 00 00 → DONE immediately after the second byte, zero writes, cpu_hold=0.
- MAX_WORDS=4, length 05 00 → ERR, err=1, byte_ready=0, no writes, cpu_hold=1. A later start followed by a valid image recovers.
- rst_n low after 6 payload bytes (one word written) → outputs at reset values. A restart loads again from BASE_ADDR.
- start pulsed during DATA → ignored; the load completes normally.
